// File: rtl/serpent_encrypt_core.sv
// serpent_encrypt_core: iterative Serpent block encryption, one round per clock.
//
// The 128-bit state X is held as four 32-bit bitslice words. Word 0 is the least
// significant bit of each S-box nibble. Round keys are fetched from an external
// key-schedule store through o_key_index / i_key_word_*.
//
// Ports:
//   i_clk, i_rst          clock (rising edge), asynchronous active-high reset
//   i_valid, o_ready      plaintext handshake
//   i_data_word_0..3      plaintext bitslice words
//   o_key_index           subkey index requested (0..32 while running, else 0)
//   i_key_word_0..3       subkey K[o_key_index], valid combinationally
//   o_valid, i_ready      ciphertext handshake
//   o_data_word_0..3      ciphertext bitslice words (always the state register)
//
// Configuration macro: SERPENT_ENC_BACKTOBACK_EN
//   When defined, a new plaintext may be loaded on the same edge that the
//   ciphertext is consumed, skipping IDLE (one block per 34 cycles).
//   When undefined, every block returns through IDLE (one block per 35 cycles).
module serpent_encrypt_core (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_data_word_0,
  input  logic [31:0] i_data_word_1,
  input  logic [31:0] i_data_word_2,
  input  logic [31:0] i_data_word_3,
  output logic [5:0]  o_key_index,
  input  logic [31:0] i_key_word_0,
  input  logic [31:0] i_key_word_1,
  input  logic [31:0] i_key_word_2,
  input  logic [31:0] i_key_word_3,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_data_word_0,
  output logic [31:0] o_data_word_1,
  output logic [31:0] o_data_word_2,
  output logic [31:0] o_data_word_3
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [5:0] SboxOnlyRound = 6'd31;
  localparam logic [5:0] FinalKeyRound = 6'd32;

  // Forward S-boxes S0..S7, entry 0 in the top nibble.
  localparam logic [63:0] SboxTbl [8] = '{
    64'h38F1A65BED42709C,
    64'hFC27905A1BE86D34,
    64'h86793CAFD1E40B52,
    64'h0FB8C963D124A75E,
    64'h1F83C0B6254A9E7D,
    64'hF52B4A9C03E8D671,
    64'h72C5846BE91FD3A0,
    64'h1DF0E82B74CA9356
  };

  function automatic logic [31:0] rol32(input logic [31:0] x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

  // Bitsliced S-box: bit i of words 3..0 forms nibble i.
  function automatic logic [127:0] sbox_fwd(input logic [2:0] idx, input logic [127:0] x);
    logic [127:0] y;
    logic [3:0]   nib;
    logic [63:0]  row;
    y = '0;
    for (int i = 0; i < 32; i++) begin
      nib = {x[96+i], x[64+i], x[32+i], x[i]};
      row = SboxTbl[idx] << {nib, 2'b00};
      {y[96+i], y[64+i], y[32+i], y[i]} = row[63:60];
    end
    return y;
  endfunction

  function automatic logic [127:0] lt_fwd(input logic [127:0] x);
    logic [31:0] a0, a1, a2, a3;
    a0 = rol32(x[31:0], 13);
    a2 = rol32(x[95:64], 3);
    a1 = x[63:32] ^ a0 ^ a2;
    a3 = x[127:96] ^ a2 ^ (a0 << 3);
    a1 = rol32(a1, 1);
    a3 = rol32(a3, 7);
    a0 = a0 ^ a1 ^ a3;
    a2 = a2 ^ a3 ^ (a1 << 7);
    a0 = rol32(a0, 5);
    a2 = rol32(a2, 22);
    return {a3, a2, a1, a0};
  endfunction

  state_e       r_state, w_state_next;
  logic [127:0] r_x, w_x_next;
  logic [5:0]   r_round, w_round_next;
  logic [127:0] w_key, w_plain, w_keyed, w_sboxed, w_mixed;

  assign w_key    = {i_key_word_3, i_key_word_2, i_key_word_1, i_key_word_0};
  assign w_plain  = {i_data_word_3, i_data_word_2, i_data_word_1, i_data_word_0};
  assign w_keyed  = r_x ^ w_key;
  // Round r uses S-box r mod 8; round 31 lands on S7 naturally.
  assign w_sboxed = sbox_fwd(r_round[2:0], w_keyed);
  assign w_mixed  = lt_fwd(w_sboxed);

  always_comb begin
    w_state_next = r_state;
    w_x_next     = r_x;
    w_round_next = r_round;
    o_ready      = 1'b0;
    o_valid      = 1'b0;
    o_key_index  = 6'd0;
    unique case (r_state)
      StIdle: begin
        o_ready = 1'b1;
        if (i_valid) begin
          w_x_next     = w_plain;
          w_round_next = 6'd0;
          w_state_next = StRun;
        end
      end
      StRun: begin
        o_key_index = r_round;
        if (r_round == FinalKeyRound) begin
          w_x_next     = w_keyed;
          w_state_next = StDone;
        end else begin
          w_x_next     = (r_round == SboxOnlyRound) ? w_sboxed : w_mixed;
          w_round_next = r_round + 6'd1;
        end
      end
      StDone: begin
        o_valid = 1'b1;
`ifdef SERPENT_ENC_BACKTOBACK_EN
        o_ready = i_ready;
        if (i_ready) begin
          w_round_next = 6'd0;
          if (i_valid) begin
            w_x_next     = w_plain;
            w_state_next = StRun;
          end else begin
            w_state_next = StIdle;
          end
        end
`else
        if (i_ready) begin
          w_round_next = 6'd0;
          w_state_next = StIdle;
        end
`endif
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_x     <= '0;
      r_round <= 6'd0;
    end else begin
      r_state <= w_state_next;
      r_x     <= w_x_next;
      r_round <= w_round_next;
    end
  end

  assign o_data_word_0 = r_x[31:0];
  assign o_data_word_1 = r_x[63:32];
  assign o_data_word_2 = r_x[95:64];
  assign o_data_word_3 = r_x[127:96];

endmodule

// File: tb/tb_serpent_encrypt_core.sv
// Self-checking bench for serpent_encrypt_core: table-driven vectors against a
// behavioural Serpent model with its own key schedule, plus directed sequences for
// backpressure, busy input, mid-run reset and back-to-back throughput.
module tb_serpent_encrypt_core;

`ifdef SERPENT_ENC_BACKTOBACK_EN
  localparam int Spacing = 34;
`else
  localparam int Spacing = 35;
`endif
  localparam int NumVec = 102;

  localparam int SB [8][16] = '{
    '{ 3,  8, 15,  1, 10,  6,  5, 11, 14, 13,  4,  2,  7,  0,  9, 12},
    '{15, 12,  2,  7,  9,  0,  5, 10,  1, 11, 14,  8,  6, 13,  3,  4},
    '{ 8,  6,  7,  9,  3, 12, 10, 15, 13,  1, 14,  4,  0, 11,  5,  2},
    '{ 0, 15, 11,  8, 12,  9,  6,  3, 13,  1,  2,  4, 10,  7,  5, 14},
    '{ 1, 15,  8,  3, 12,  0, 11,  6,  2,  5,  4, 10,  9, 14,  7, 13},
    '{15,  5,  2, 11,  4, 10,  9, 12,  0,  3, 14,  8, 13,  6,  7,  1},
    '{ 7,  2, 12,  5,  8,  4,  6, 11, 14,  9,  1, 15, 13,  3, 10,  0},
    '{ 1, 13, 15,  0, 14,  8,  2, 11,  7,  4, 12, 10,  9,  3,  5,  6}
  };

  typedef struct {
    bit           zero_keys;
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] exp_ct;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid, o_ready, o_valid, i_ready;
  logic [31:0] d0, d1, d2, d3, k0, k1, k2, k3, q0, q1, q2, q3;
  logic [5:0]  o_key_index;
  logic [127:0] dout;
  logic [127:0] sk [64];

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign {k3, k2, k1, k0} = sk[o_key_index];
  assign dout = {q3, q2, q1, q0};

  serpent_encrypt_core dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_data_word_0(d0),
    .i_data_word_1(d1),
    .i_data_word_2(d2),
    .i_data_word_3(d3),
    .o_key_index  (o_key_index),
    .i_key_word_0 (k0),
    .i_key_word_1 (k1),
    .i_key_word_2 (k2),
    .i_key_word_3 (k3),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_data_word_0(q0),
    .o_data_word_1(q1),
    .o_data_word_2(q2),
    .o_data_word_3(q3)
  );

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting for the core", name);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [127:0] m_sbox(input int box, input logic [127:0] x);
    logic [127:0] y = '0;
    int v, o;
    for (int i = 0; i < 32; i++) begin
      v = int'(x[i]) + 2 * int'(x[32+i]) + 4 * int'(x[64+i]) + 8 * int'(x[96+i]);
      o = SB[box][v];
      y[i] = o[0]; y[32+i] = o[1]; y[64+i] = o[2]; y[96+i] = o[3];
    end
    return y;
  endfunction

  function automatic logic [127:0] m_lt(input logic [127:0] x);
    logic [31:0] w [4];
    for (int i = 0; i < 4; i++) w[i] = x[32*i +: 32];
    w[0] = rotl(w[0], 13);
    w[2] = rotl(w[2], 3);
    w[1] = w[1] ^ w[0] ^ w[2];
    w[3] = w[3] ^ w[2] ^ (w[0] << 3);
    w[1] = rotl(w[1], 1);
    w[3] = rotl(w[3], 7);
    w[0] = w[0] ^ w[1] ^ w[3];
    w[2] = w[2] ^ w[3] ^ (w[1] << 7);
    w[0] = rotl(w[0], 5);
    w[2] = rotl(w[2], 22);
    return {w[3], w[2], w[1], w[0]};
  endfunction

  function automatic logic [127:0] m_encrypt(input logic [127:0] pt);
    logic [127:0] x = pt;
    for (int r = 0; r < 32; r++) begin
      x = m_sbox(r % 8, x ^ sk[r]);
      if (r != 31) x = m_lt(x);
    end
    return x ^ sk[32];
  endfunction

  // Serpent key schedule (128-bit key padded with a single 1 bit), bitsliced subkeys.
  task automatic set_keys(input bit zero, input logic [127:0] key);
    logic [31:0]  w [140];
    logic [255:0] kp;
    logic [31:0]  t;
    kp = {127'd0, 1'b1, key};
    for (int i = 0; i < 64; i++) sk[i] = '0;
    if (!zero) begin
      for (int i = 0; i < 8; i++) w[i] = kp[32*i +: 32];
      for (int i = 0; i < 132; i++) begin
        t = w[i] ^ w[i+3] ^ w[i+5] ^ w[i+7] ^ 32'h9e3779b9 ^ i;
        w[i+8] = rotl(t, 11);
      end
      for (int j = 0; j < 33; j++)
        sk[j] = m_sbox((35 - j) % 8, {w[8+4*j+3], w[8+4*j+2], w[8+4*j+1], w[8+4*j]});
    end
  endtask

  // ---------------- stimulus helpers (called at a falling edge) ----------------
  task automatic start_block(input logic [127:0] pt);
    int n = 0;
    while (!o_ready && n < 100) begin @(negedge clk); n++; end
    if (!o_ready) fail_now("accept_wait");
    {d3, d2, d1, d0} = pt;
    i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  task automatic run_block(input logic [127:0] pt, input int pulse_at, input logic [127:0] alt,
                           output logic [127:0] ct, output int lat, output bit idx_ok,
                           output bit busy_ok);
    start_block(pt);
    lat = 0; idx_ok = 1'b1; busy_ok = 1'b1;
    while (!o_valid && lat < 60) begin
      if (o_key_index != 6'(lat)) idx_ok = 1'b0;
      if (o_ready) busy_ok = 1'b0;
      if (lat == pulse_at) begin
        {d3, d2, d1, d0} = alt;
        i_valid = 1'b1;
      end else begin
        i_valid = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    i_valid = 1'b0;
    if (!o_valid) fail_now("valid_wait");
    ct = dout;
  endtask

  task automatic consume(input int hold);
    logic [127:0] held;
    bit stable;
    held = dout;
    stable = 1'b1;
    i_ready = 1'b0;
    repeat (hold) begin
      @(negedge clk);
      if (dout !== held || !o_valid || o_ready) stable = 1'b0;
    end
    if (hold > 0) check("backpressure_stable", stable, 1'b1);
    i_ready = 1'b1;
    @(negedge clk);
    i_ready = 1'b0;
    check("idle_after_handshake", {o_valid, o_ready, o_key_index}, {1'b0, 1'b1, 6'd0});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         vecs [NumVec];
    logic [127:0] ct, pts [3], outs [3];
    int           lat, n, cyc, blk_in, blk_out, n_rise;
    int           rise [3];
    bit           idx_ok, busy_ok, quiet, prev_v;

    rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0;
    {d3, d2, d1, d0} = '0;
    set_keys(1'b1, '0);

    // Vector table: all-zero subkeys, key 0x80..0, then random keys/plaintexts.
    vecs[0] = '{zero_keys: 1'b1, key: '0, pt: '0, exp_ct: '0};
    vecs[1] = '{zero_keys: 1'b0, key: 128'h80000000_00000000_00000000_00000000, pt: '0,
                exp_ct: '0};
    for (int i = 2; i < NumVec; i++)
      vecs[i] = '{zero_keys: 1'b0, key: {$urandom, $urandom, $urandom, $urandom},
                  pt: {$urandom, $urandom, $urandom, $urandom}, exp_ct: '0};
    for (int i = 0; i < NumVec; i++) begin
      set_keys(vecs[i].zero_keys, vecs[i].key);
      vecs[i].exp_ct = m_encrypt(vecs[i].pt);
    end

    #2;
    check("reset_outputs", {o_ready, o_valid, o_key_index, dout},
          {1'b1, 1'b0, 6'd0, 128'd0});
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NumVec; i++) begin
      set_keys(vecs[i].zero_keys, vecs[i].key);
      run_block(vecs[i].pt, -1, '0, ct, lat, idx_ok, busy_ok);
      check($sformatf("latency[%0d]", i), lat, 33);
      check($sformatf("key_index_seq[%0d]", i), idx_ok, 1'b1);
      check($sformatf("ciphertext[%0d]", i), ct, vecs[i].exp_ct);
      consume(0);
    end

    // Busy input: a second plaintext pulsed during RUN must be ignored.
    set_keys(1'b0, vecs[1].key);
    run_block(128'h0123456789abcdef_fedcba9876543210, 10,
              128'hdeadbeefcafef00d_0badc0de12345678, ct, lat, idx_ok, busy_ok);
    check("busy_ready_low", busy_ok, 1'b1);
    check("busy_ciphertext", ct, m_encrypt(128'h0123456789abcdef_fedcba9876543210));
    consume(0);

    // Backpressure: hold the result for 50 cycles.
    run_block(vecs[5].pt, -1, '0, ct, lat, idx_ok, busy_ok);
    check("bp_ciphertext", ct, m_encrypt(vecs[5].pt));
    consume(50);

    // Reset at round 17: outputs return to reset values at once, no result emerges.
    start_block(vecs[6].pt);
    n = 0;
    while (o_key_index != 6'd17 && n < 60) begin @(negedge clk); n++; end
    check("reach_round17", o_key_index, 6'd17);
    rst = 1'b1;
    #1;
    check("midrun_reset_outputs", {o_ready, o_valid, o_key_index, dout},
          {1'b1, 1'b0, 6'd0, 128'd0});
    @(negedge clk);
    rst = 1'b0;
    quiet = 1'b1;
    repeat (45) begin
      @(negedge clk);
      if (o_valid) quiet = 1'b0;
    end
    check("aborted_block_silent", quiet, 1'b1);
    run_block(vecs[7].pt, -1, '0, ct, lat, idx_ok, busy_ok);
    check("after_reset_ciphertext", ct, m_encrypt(vecs[7].pt));
    consume(0);

    // Back-to-back: valid and ready held high for three blocks.
    for (int i = 0; i < 3; i++) pts[i] = vecs[10+i].pt;
    i_ready = 1'b1;
    blk_in = 0; blk_out = 0; n_rise = 0; prev_v = 1'b0; cyc = 0;
    while (blk_out < 3 && cyc < 200) begin
      if (o_valid && !prev_v && n_rise < 3) begin rise[n_rise] = cyc; n_rise++; end
      prev_v = o_valid;
      if (o_valid) begin outs[blk_out] = dout; blk_out++; end
      if (o_ready) begin
        if (blk_in < 3) begin
          {d3, d2, d1, d0} = pts[blk_in];
          i_valid = 1'b1;
          blk_in++;
        end else begin
          i_valid = 1'b0;
        end
      end
      @(negedge clk);
      cyc++;
    end
    i_valid = 1'b0;
    i_ready = 1'b0;
    check("b2b_blocks_out", blk_out, 3);
    check("b2b_rises", n_rise, 3);
    if (n_rise == 3) begin
      check("b2b_spacing_1", rise[1] - rise[0], Spacing);
      check("b2b_spacing_2", rise[2] - rise[1], Spacing);
    end
    for (int i = 0; i < blk_out; i++)
      check($sformatf("b2b_ciphertext[%0d]", i), outs[i], m_encrypt(pts[i]));
    check("b2b_final_idle", {o_valid, o_ready}, {1'b0, 1'b1});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
